// File: rtl/noc_pkg.sv
// Shared router definitions: port count, select width, port indices and
// the mod-5 arithmetic used to rotate round-robin priority pointers.
package noc_pkg;

  localparam int NUM_PORTS  = 5;
  localparam int PORT_SEL_W = 3;

  localparam logic [PORT_SEL_W-1:0] PORT_A = 3'd0;
  localparam logic [PORT_SEL_W-1:0] PORT_B = 3'd1;
  localparam logic [PORT_SEL_W-1:0] PORT_C = 3'd2;
  localparam logic [PORT_SEL_W-1:0] PORT_D = 3'd3;
  localparam logic [PORT_SEL_W-1:0] PORT_E = 3'd4;

  typedef logic [PORT_SEL_W-1:0] port_idx_t;

  // (a + b) mod 5 for operands already in 0..4
  function automatic port_idx_t add_mod5(input port_idx_t a, input port_idx_t b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 4'd5) s = s - 4'd5;
    return s[PORT_SEL_W-1:0];
  endfunction

  // Next priority position after index v, wrapping 4 -> 0
  function automatic port_idx_t inc_mod5(input port_idx_t v);
    return add_mod5(v, 3'd1);
  endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational rotating-priority picker over five inputs. The scan starts
// at ptr and wraps mod 5; the first set bit of mask wins.
module rr_pick5 import noc_pkg::*; (
  input  logic [NUM_PORTS-1:0] mask,
  input  port_idx_t            ptr,
  output logic [NUM_PORTS-1:0] onehot,
  output port_idx_t            idx,
  output logic                 any
);

  port_idx_t cand;

  // Walk from the lowest priority position upwards so the entry nearest ptr overwrites the rest
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = add_mod5(ptr, PORT_SEL_W'(k));
      if (mask[cand]) begin
        onehot       = '0;
        onehot[cand] = 1'b1;
        idx          = cand;
        any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/outport_arb5.sv
// Round-robin output-port arbiter feeding the mux5to1 crossbar leg.
// Define OUTARB_WORMHOLE_EN to hold the grant from head flit to tail flit;
// without it the arbiter rotates priority after every flit.
module outport_arb5 import noc_pkg::*; #(
  parameter int NUM_IN  = 5,
  parameter int SEL_W   = 3,
  parameter int RST_PTR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] req,
  input  logic [NUM_IN-1:0] head,
  input  logic [NUM_IN-1:0] tail,
  input  logic              out_ready,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  sel,
  output logic              out_valid,
  output logic              locked
);

  if (NUM_IN != NUM_PORTS || SEL_W != PORT_SEL_W) begin : g_bad_cfg
    $error("outport_arb5 supports only NUM_IN=5 and SEL_W=3");
  end
  if (RST_PTR < 0 || RST_PTR > 4) begin : g_bad_ptr
    $error("outport_arb5 RST_PTR must be in 0..4");
  end

  localparam port_idx_t RST_PTR_V = PORT_SEL_W'(RST_PTR);

  logic [NUM_PORTS-1:0] elig;
  logic [NUM_PORTS-1:0] pick_oh;
  port_idx_t            pick_idx;
  logic                 pick_any;
  logic [NUM_PORTS-1:0] grant_raw;
  port_idx_t            win_idx;
  port_idx_t            ptr;
  port_idx_t            sel_q;
  logic                 xfer;

  rr_pick5 u_pick (
    .mask   (elig),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

`ifdef OUTARB_WORMHOLE_EN
  logic      lock;
  port_idx_t lock_idx;

  // Unlocked: only head flits compete; locked: the owning input alone may be granted
  always_comb begin
    elig      = req & head;
    grant_raw = pick_any ? pick_oh : '0;
    win_idx   = pick_idx;
    if (lock) begin
      grant_raw           = '0;
      grant_raw[lock_idx] = req[lock_idx];
      win_idx             = lock_idx;
    end
  end

  // Open a lock on a multi-flit head, release it and rotate on the tail
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= RST_PTR_V;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else if (xfer) begin
      if (lock) begin
        if (tail[lock_idx]) begin
          lock <= 1'b0;
          ptr  <= inc_mod5(lock_idx);
        end
      end else if (head[pick_idx] && !tail[pick_idx]) begin
        lock     <= 1'b1;
        lock_idx <= pick_idx;
      end else begin
        ptr <= inc_mod5(pick_idx);
      end
    end
  end

  assign locked = lock;
`else
  logic unused_flit_marks;

  // Per-flit arbitration: every requester is eligible regardless of flit type
  always_comb begin
    elig      = req;
    grant_raw = pick_any ? pick_oh : '0;
    win_idx   = pick_idx;
  end

  // Rotate priority past the winner after every accepted flit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= RST_PTR_V;
    end else if (xfer) begin
      ptr <= inc_mod5(pick_idx);
    end
  end

  assign unused_flit_marks = ^{head, tail};
  assign locked            = 1'b0;
`endif

  // Reset forces the grant off immediately, without waiting for a clock
  always_comb begin
    grant = reset ? '0 : grant_raw;
  end

  assign out_valid = |grant;
  assign sel       = out_valid ? win_idx : sel_q;
  assign xfer      = out_valid & out_ready;

  // Remember the last granted index so the mux select stays put while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q <= '0;
    end else if (out_valid) begin
      sel_q <= win_idx;
    end
  end

endmodule

// File: tb/tb_outport_arb5.sv
// Self-checking bench for outport_arb5: a constant vector table, hand-written
// wormhole / reset sequences, and a randomized run against a behavioural model.
// Build with or without OUTARB_WORMHOLE_EN; the bench follows the same macro.
module tb_outport_arb5;

`ifdef OUTARB_WORMHOLE_EN
  localparam bit WH = 1'b1;
`else
  localparam bit WH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] req, head, tail;
  logic       out_ready;
  logic [4:0] grant;
  logic [2:0] sel;
  logic       out_valid, locked;

  int n_vec = 0;
  int n_err = 0;

  // Model state: priority pointer, lock flag and owner, last select value
  int m_ptr, m_lidx, m_sel;
  bit m_lock;

  typedef struct {
    logic [4:0] req;
    logic       rdy;
    logic [4:0] g;
    logic [2:0] s;
    logic       v;
  } vec_t;

  vec_t vecs[$];

  outport_arb5 dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .head      (head),
    .tail      (tail),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel),
    .out_valid (out_valid),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs just after the rising edge, return at the falling edge
  task automatic applyStimulus(input logic [4:0] r, input logic [4:0] h,
                               input logic [4:0] t, input logic rdy);
    @(posedge clk);
    #1;
    req       = r;
    head      = h;
    tail      = t;
    out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [4:0] eg,
                             input logic [2:0] es, input logic ev, input logic el);
    n_vec++;
    if ({grant, sel, out_valid, locked} !== {eg, es, ev, el}) begin
      n_err++;
      $display("[TB] FAIL %s: got grant=%b sel=%0d valid=%b locked=%b, want grant=%b sel=%0d valid=%b locked=%b",
               name, grant, sel, out_valid, locked, eg, es, ev, el);
    end
  endtask

  task automatic add_vec(input logic [4:0] r, input logic rdy, input logic [4:0] g,
                         input logic [2:0] s, input logic v);
    vec_t e;
    e.req = r; e.rdy = rdy; e.g = g; e.s = s; e.v = v;
    vecs.push_back(e);
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_lidx = 0;
    m_sel  = 0;
    m_lock = 1'b0;
  endtask

  // Hold reset for a cycle, then release with the inputs idle
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req       = '0;
    head      = '0;
    tail      = '0;
    out_ready = 1'b0;
    model_reset();
  endtask

  // Winner from the arbitration rules: lock owner if locked, else first eligible from ptr
  task automatic model_eval(input logic [4:0] r, input logic [4:0] h,
                            output logic [4:0] g, output int w);
    g = '0;
    w = -1;
    if (m_lock) begin
      w = m_lidx;
      if (r[m_lidx]) g[m_lidx] = 1'b1;
    end else begin
      for (int k = 0; k < 5; k++) begin
        int i;
        i = (m_ptr + k) % 5;
        if (w < 0 && r[i] && (!WH || h[i])) begin
          w    = i;
          g[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_commit(input logic [4:0] g, input int w,
                              input logic [4:0] h, input logic [4:0] t, input logic rdy);
    if (g != 0) m_sel = w;
    if (g != 0 && rdy) begin
      if (m_lock) begin
        if (t[m_lidx]) begin
          m_lock = 1'b0;
          m_ptr  = (m_lidx + 1) % 5;
        end
      end else if (WH && h[w] && !t[w]) begin
        m_lock = 1'b1;
        m_lidx = w;
      end else begin
        m_ptr = (w + 1) % 5;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0] r, h, t, g;
    logic       rdy;
    int         w;
    logic [2:0] es;

    reset     = 1'b1;
    req       = 5'b11111;
    head      = 5'b11111;
    tail      = 5'b11111;
    out_ready = 1'b1;
    #3;
    checkOutput("reset_hold_a", 5'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("reset_hold_b", 5'b0, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req       = '0;
    out_ready = 1'b0;

    // Rotation, wrap, backpressure and select hold; all flits single-flit packets
    add_vec(5'b11111, 1'b1, 5'b00001, 3'd0, 1'b1);
    add_vec(5'b11111, 1'b1, 5'b00010, 3'd1, 1'b1);
    add_vec(5'b11111, 1'b1, 5'b00100, 3'd2, 1'b1);
    add_vec(5'b11111, 1'b1, 5'b01000, 3'd3, 1'b1);
    add_vec(5'b11111, 1'b1, 5'b10000, 3'd4, 1'b1);
    add_vec(5'b11111, 1'b1, 5'b00001, 3'd0, 1'b1);
    add_vec(5'b00100, 1'b1, 5'b00100, 3'd2, 1'b1);
    add_vec(5'b00001, 1'b1, 5'b00001, 3'd0, 1'b1);
    add_vec(5'b00011, 1'b0, 5'b00010, 3'd1, 1'b1);
    add_vec(5'b00110, 1'b0, 5'b00010, 3'd1, 1'b1);
    add_vec(5'b00110, 1'b0, 5'b00010, 3'd1, 1'b1);
    add_vec(5'b00110, 1'b0, 5'b00010, 3'd1, 1'b1);
    add_vec(5'b00110, 1'b1, 5'b00010, 3'd1, 1'b1);
    add_vec(5'b00110, 1'b1, 5'b00100, 3'd2, 1'b1);
    add_vec(5'b00000, 1'b1, 5'b00000, 3'd2, 1'b0);
    add_vec(5'b10001, 1'b1, 5'b10000, 3'd4, 1'b1);
    add_vec(5'b10001, 1'b0, 5'b00001, 3'd0, 1'b1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, 5'b11111, 5'b11111, vecs[i].rdy);
      checkOutput($sformatf("table%0d", i), vecs[i].g, vecs[i].s, vecs[i].v, 1'b0);
    end

    do_reset();
`ifdef OUTARB_WORMHOLE_EN
    // Move priority to input 4, then a 4-flit packet on 4 against a head on 0
    applyStimulus(5'b01000, 5'b01000, 5'b01000, 1'b1);
    checkOutput("wh_setup", 5'b01000, 3'd3, 1'b1, 1'b0);
    applyStimulus(5'b10001, 5'b10001, 5'b00000, 1'b1);
    checkOutput("wh_head", 5'b10000, 3'd4, 1'b1, 1'b0);
    applyStimulus(5'b10001, 5'b00001, 5'b00000, 1'b1);
    checkOutput("wh_body1", 5'b10000, 3'd4, 1'b1, 1'b1);
    applyStimulus(5'b00001, 5'b00001, 5'b00000, 1'b1);
    checkOutput("wh_drop", 5'b00000, 3'd4, 1'b0, 1'b1);
    applyStimulus(5'b10001, 5'b00001, 5'b00000, 1'b1);
    checkOutput("wh_body2", 5'b10000, 3'd4, 1'b1, 1'b1);
    applyStimulus(5'b10001, 5'b00001, 5'b10000, 1'b1);
    checkOutput("wh_tail", 5'b10000, 3'd4, 1'b1, 1'b1);
    applyStimulus(5'b00001, 5'b00001, 5'b00001, 1'b1);
    checkOutput("wh_next", 5'b00001, 3'd0, 1'b1, 1'b0);

    // Lock input 1, then reset between clock edges
    applyStimulus(5'b00010, 5'b00010, 5'b00000, 1'b1);
    checkOutput("rst_head", 5'b00010, 3'd1, 1'b1, 1'b0);
    applyStimulus(5'b00010, 5'b00000, 5'b00000, 1'b0);
    checkOutput("rst_locked", 5'b00010, 3'd1, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async", 5'b00000, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    applyStimulus(5'b00110, 5'b00100, 5'b00000, 1'b1);
    checkOutput("rst_fresh", 5'b00100, 3'd2, 1'b1, 1'b0);
`else
    // Same traffic as the wormhole case: inputs 0 and 4 alternate flit by flit
    applyStimulus(5'b10001, 5'b10001, 5'b00000, 1'b1);
    checkOutput("flit_a0", 5'b00001, 3'd0, 1'b1, 1'b0);
    applyStimulus(5'b10001, 5'b00000, 5'b00000, 1'b1);
    checkOutput("flit_e0", 5'b10000, 3'd4, 1'b1, 1'b0);
    applyStimulus(5'b10001, 5'b00000, 5'b00000, 1'b1);
    checkOutput("flit_a1", 5'b00001, 3'd0, 1'b1, 1'b0);
    applyStimulus(5'b10001, 5'b00000, 5'b10000, 1'b1);
    checkOutput("flit_e1", 5'b10000, 3'd4, 1'b1, 1'b0);
    applyStimulus(5'b11111, 5'b00000, 5'b00000, 1'b0);
    checkOutput("flit_idle", 5'b00001, 3'd0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async", 5'b00000, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    applyStimulus(5'b00110, 5'b00100, 5'b00000, 1'b1);
    checkOutput("rst_fresh", 5'b00010, 3'd1, 1'b1, 1'b0);
`endif

    // Randomized traffic compared with the behavioural model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r   = 5'($urandom);
      h   = 5'($urandom);
      t   = 5'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      applyStimulus(r, h, t, rdy);
      model_eval(r, h, g, w);
      es = (g != 0) ? 3'(w) : 3'(m_sel);
      checkOutput($sformatf("rand%0d", n), g, es, (g != 0), m_lock);
      model_commit(g, w, h, t, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
